fft_axil_ctrl_regs: RTL and testbench

- Parametrised AXI4-Lite slave register block; next generation of the 4-register slave on the FFT IP's S00_AXI port.
- Adds configurable register count, byte strobes, SLVERR decode, a start/busy/done handshake to the FFT core, sticky W1C status and an interrupt.
- Sits between the PS AXI interconnect and fft_parallel core control inputs.

---
 rtl/fft_axil_ctrl_regs.sv | 269 ++++++++++++++++++++++++++
 tb/tb_fft_axil_ctrl_regs.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_axil_ctrl_regs.sv
// AXI4-Lite control/status register slave for the FFT core: CTRL, sticky STATUS,
// byte-strobed USER registers, start/done handshake and a level interrupt.
module fft_axil_ctrl_regs #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS           = 8,
    parameter int unsigned MODE_WIDTH         = 4
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic [2:0]                             s_axi_awprot,
    input  logic                                   s_axi_awvalid,
    output logic                                   s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                                   s_axi_wvalid,
    output logic                                   s_axi_wready,
    output logic [1:0]                             s_axi_bresp,
    output logic                                   s_axi_bvalid,
    input  logic                                   s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic [2:0]                             s_axi_arprot,
    input  logic                                   s_axi_arvalid,
    output logic                                   s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                             s_axi_rresp,
    output logic                                   s_axi_rvalid,
    input  logic                                   s_axi_rready,
    output logic                                   core_start,
    input  logic                                   core_busy,
    input  logic                                   core_done,
    output logic [MODE_WIDTH-1:0]                  cfg_mode,
    output logic [(NUM_REGS-2)*C_S_AXI_DATA_WIDTH-1:0] cfg_user,
    output logic                                   irq
);

    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW       = DW / 8;
    localparam int unsigned IDX_W    = C_S_AXI_ADDR_WIDTH - 2;
    localparam int unsigned NUM_USER = NUM_REGS - 2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_e;

    // Write channel state
    logic              aw_have_q, aw_have_d;
    logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
    logic              w_have_q, w_have_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [SW-1:0]     wstrb_q, wstrb_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;

    // Register file and core handshake
    logic                  irq_en_q, irq_en_d;
    logic [MODE_WIDTH-1:0] mode_q, mode_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  start_q, start_d;
    logic                  irq_q, irq_d;
    logic [DW-1:0]         user_q [NUM_USER];
    logic [DW-1:0]         user_d [NUM_USER];

    // Read channel state
    rstate_e           rstate_q, rstate_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic              aw_hs, w_hs, commit, w_idx_ok;
    logic              done_clr, err_clr, err_set;
    logic [IDX_W-1:0]  ar_idx;
    logic              rd_ok;
    logic [DW-1:0]     rd_word, ctrl_word, status_word;

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign aw_hs    = s_axi_awvalid && awready_q;
    assign w_hs     = s_axi_wvalid && wready_q;
    assign commit   = aw_have_q && w_have_q;
    assign w_idx_ok = 32'(aw_idx_q) < NUM_REGS;

    // Write channel, register updates and core handshake
    always_comb begin
        aw_have_d = aw_have_q;
        aw_idx_d  = aw_idx_q;
        w_have_d  = w_have_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        irq_en_d  = irq_en_q;
        mode_d    = mode_q;
        start_d   = 1'b0;
        user_d    = user_q;
        done_clr  = 1'b0;
        err_clr   = 1'b0;
        err_set   = 1'b0;

        if (aw_hs) begin
            aw_have_d = 1'b1;
            aw_idx_d  = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
            w_have_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end

        if (commit) begin
            aw_have_d = 1'b0;
            w_have_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_idx_ok ? RESP_OKAY : RESP_SLVERR;
            if (aw_idx_q == IDX_W'(0)) begin
                if (wstrb_q[0]) begin
                    irq_en_d = wdata_q[1];
                    // A start request while the core is running is refused and flagged
                    if (wdata_q[0]) begin
                        if (core_busy) err_set = 1'b1;
                        else           start_d = 1'b1;
                    end
                end
                if (wstrb_q[1]) mode_d = wdata_q[8 +: MODE_WIDTH];
            end else if (aw_idx_q == IDX_W'(1)) begin
                if (wstrb_q[0]) begin
                    done_clr = wdata_q[1];
                    err_clr  = wdata_q[2];
                end
            end else begin
                for (int unsigned i = 0; i < NUM_USER; i++) begin
                    if (32'(aw_idx_q) == 32'(i + 2)) begin
                        for (int unsigned b = 0; b < SW; b++) begin
                            if (wstrb_q[b]) user_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                        end
                    end
                end
            end
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        // Sticky bits: a set in the same cycle as a W1C wins
        done_d    = (done_q & ~done_clr) | core_done;
        err_d     = (err_q & ~err_clr) | err_set;
        irq_d     = irq_en_q & done_q;
        awready_d = !aw_have_d && !bvalid_d;
        wready_d  = !w_have_d && !bvalid_d;
    end

    // Read word selection from current register state
    always_comb begin
        ar_idx                   = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
        rd_ok                    = 32'(ar_idx) < NUM_REGS;
        ctrl_word                = '0;
        ctrl_word[1]             = irq_en_q;
        ctrl_word[8 +: MODE_WIDTH] = mode_q;
        status_word              = '0;
        status_word[0]           = core_busy;
        status_word[1]           = done_q;
        status_word[2]           = err_q;
        rd_word                  = '0;
        if (ar_idx == IDX_W'(0)) begin
            rd_word = ctrl_word;
        end else if (ar_idx == IDX_W'(1)) begin
            rd_word = status_word;
        end else begin
            for (int unsigned i = 0; i < NUM_USER; i++) begin
                if (32'(ar_idx) == 32'(i + 2)) rd_word = user_q[i];
            end
        end
    end

    // Read FSM next state and outputs
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                if (s_axi_arvalid && arready_q) begin
                    rstate_d = R_DATA;
                    rdata_d  = rd_word;
                    rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: begin
                if (s_axi_rready) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
        arready_d = (rstate_d == R_IDLE);
        rvalid_d  = (rstate_d == R_DATA);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            aw_have_q <= 1'b0;
            aw_idx_q  <= '0;
            w_have_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            irq_en_q  <= 1'b0;
            mode_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            irq_q     <= 1'b0;
            for (int unsigned i = 0; i < NUM_USER; i++) user_q[i] <= '0;
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            aw_have_q <= aw_have_d;
            aw_idx_q  <= aw_idx_d;
            w_have_q  <= w_have_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            irq_en_q  <= irq_en_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            err_q     <= err_d;
            start_q   <= start_d;
            irq_q     <= irq_d;
            user_q    <= user_d;
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_USER; i++) cfg_user[i*DW +: DW] = user_q[i];
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign core_start    = start_q;
    assign cfg_mode      = mode_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_fft_axil_ctrl_regs.sv
// Bench for fft_axil_ctrl_regs: directed scenarios plus randomized traffic
// compared against a register-level model of the programmer-visible behaviour.
module tb_fft_axil_ctrl_regs;

    localparam int unsigned AW = 6;
    localparam int unsigned NR = 8;
    localparam int unsigned MW = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [AW-1:0]        awaddr = '0, araddr = '0;
    logic                 awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0]          wdata = '0;
    logic [3:0]           wstrb = '0;
    logic                 awready, wready, bvalid, arready, rvalid;
    logic [1:0]           bresp, rresp;
    logic [31:0]          rdata;
    logic                 core_start, core_busy = 0, core_done = 0, irq;
    logic [MW-1:0]        cfg_mode;
    logic [(NR-2)*32-1:0] cfg_user;

    fft_axil_ctrl_regs #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR), .MODE_WIDTH(MW)
    ) dut (
        .clock(clock), .reset(reset),
        .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
        .cfg_mode(cfg_mode), .cfg_user(cfg_user), .irq(irq)
    );

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;
    int exp_starts = 0;

    // Reference register state
    logic [31:0]   m_user [NR-2];
    logic          m_irq_en, m_done, m_err;
    logic [MW-1:0] m_mode;

    always @(negedge clock) if (core_start === 1'b1) start_cnt++;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NR) - 2; i++) m_user[i] = '0;
        m_irq_en = 0; m_done = 0; m_err = 0; m_mode = '0;
    endtask

    function automatic logic [31:0] m_read(input int idx);
        logic [31:0] v = '0;
        if (idx == 0) begin
            v[1] = m_irq_en;
            v[8 +: MW] = m_mode;
        end else if (idx == 1) begin
            v = {29'd0, m_err, m_done, core_busy};
        end else if (idx < int'(NR)) begin
            v = m_user[idx-2];
        end
        return v;
    endfunction

    task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s, input bit pulse_done);
        if (idx == 0) begin
            if (s[0]) begin
                m_irq_en = d[1];
                if (d[0]) begin
                    if (core_busy) m_err = 1;
                    else exp_starts++;
                end
            end
            if (s[1]) m_mode = d[8 +: MW];
        end else if (idx == 1) begin
            if (s[0] && d[1]) m_done = 0;
            if (s[0] && d[2]) m_err = 0;
        end else if (idx < int'(NR)) begin
            for (int b = 0; b < 4; b++) if (s[b]) m_user[idx-2][8*b +: 8] = d[8*b +: 8];
        end
        if (pulse_done) m_done = 1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clock); #1; end
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly, input bit pulse_done,
                             output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, ar_s, wr_s;
        int n = 0;
        resp = 2'bxx;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && n < 40) begin
            if (!aw_done && n >= aw_dly) awvalid = 1;
            if (!w_done && n >= w_dly) wvalid = 1;
            ar_s = awready; wr_s = wready;
            @(posedge clock); #1;
            if (awvalid && ar_s) begin aw_done = 1; awvalid = 0; end
            if (wvalid && wr_s) begin w_done = 1; wvalid = 0; end
            n++;
        end
        if (!(aw_done && w_done)) begin
            check_eq("aw_w_timeout", 0, 1);
            awvalid = 0; wvalid = 0;
            return;
        end
        if (pulse_done) core_done = 1;
        n = 0;
        while (bvalid !== 1'b1 && n < 20) begin @(posedge clock); #1; core_done = 0; n++; end
        core_done = 0;
        if (bvalid !== 1'b1) begin
            check_eq("bvalid_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < b_dly; i++) begin
            @(posedge clock); #1;
            check_eq("bvalid_hold", bvalid, 1);
            check_eq("awready_low", awready, 0);
        end
        resp = bresp;
        bready = 1;
        @(posedge clock); #1;
        bready = 0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit done = 0, r_s;
        int n = 0;
        araddr = addr; arvalid = 1;
        while (!done && n < 20) begin
            r_s = arready;
            @(posedge clock); #1;
            if (r_s) done = 1;
            n++;
        end
        arvalid = 0;
        data = 'x; resp = 'x;
        if (!done) begin
            check_eq("ar_timeout", 0, 1);
            return;
        end
        check_eq("rvalid", rvalid, 1);
        data = rdata; resp = rresp;
        rready = 1;
        @(posedge clock); #1;
        rready = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [(NR-2)*32-1:0] u;
        for (int i = 0; i < int'(NR) - 2; i++) u[i*32 +: 32] = m_user[i];
        check_eq({tag, "_mode"}, cfg_mode, m_mode);
        check_eq({tag, "_user"}, cfg_user, u);
        check_eq({tag, "_irq"}, irq, m_irq_en & m_done);
        check_eq({tag, "_starts"}, start_cnt, exp_starts);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, input int bd, input bit pd);
        logic [1:0] resp;
        int idx = int'(addr[AW-1:2]);
        axi_write(addr, d, s, awd, wd, bd, pd, resp);
        check_eq("bresp", resp, (idx < int'(NR)) ? 2'b00 : 2'b10);
        model_write(idx, d, s, pd);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, output logic [31:0] d);
        logic [1:0] resp;
        int idx = int'(addr[AW-1:2]);
        logic [31:0] exp = m_read(idx);
        axi_read(addr, d, resp);
        check_eq("rdata", d, exp);
        check_eq("rresp", resp, (idx < int'(NR)) ? 2'b00 : 2'b10);
    endtask

    task automatic pulse_core_done();
        core_done = 1;
        tick(1);
        core_done = 0;
        m_done = 1;
        tick(1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  resp;
        int          s0;

        model_reset();
        reset = 1;
        tick(3);
        check_eq("rst_awready", awready, 0);
        check_eq("rst_arready", arready, 0);
        check_eq("rst_bvalid", bvalid, 0);
        check_eq("rst_rvalid", rvalid, 0);
        check_eq("rst_irq", irq, 0);
        check_eq("rst_start", core_start, 0);
        check_eq("rst_rdata", rdata, 0);
        reset = 0;
        tick(1);
        check_eq("post_rst_awready", awready, 1);
        check_eq("post_rst_wready", wready, 1);
        check_eq("post_rst_arready", arready, 1);
        check_outputs("reset");

        // USER write / read-back
        for (int i = 0; i < 4; i++) do_write(AW'(8 + 4*i), 32'(i + 1), 4'hF, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            do_read(AW'(8 + 4*i), rd);
            check_eq("user_seq", rd, 32'(i + 1));
        end
        check_eq("cfg_user0", cfg_user[31:0], 32'h1);

        // Byte strobes
        do_write(AW'(8), 32'hAABBCCDD, 4'hF, 0, 0, 0, 0);
        do_write(AW'(8), 32'h11223344, 4'b0101, 0, 0, 0, 0);
        do_read(AW'(8), rd);
        check_eq("strobe_merge", rd, 32'hAA22CC44);

        // W ahead of AW
        s0 = start_cnt;
        do_write(AW'(0), 32'h00000302, 4'hF, 3, 0, 0, 0);
        tick(3);
        check_eq("single_b", bvalid, 0);
        check_eq("mode3", cfg_mode, 3);
        do_read(AW'(0), rd);
        check_eq("ctrl_rb", rd, 32'h302);
        check_eq("no_start", start_cnt, s0);
        check_outputs("w_first");

        // Start, done, interrupt, W1C
        do_write(AW'(0), 32'h3, 4'hF, 0, 0, 0, 0);
        tick(2);
        check_eq("one_start", start_cnt, s0 + 1);
        pulse_core_done();
        do_read(AW'(4), rd);
        check_eq("status_done", rd, 32'h2);
        check_eq("irq_set", irq, 1);
        do_write(AW'(4), 32'h2, 4'hF, 0, 0, 0, 0);
        tick(1);
        do_read(AW'(4), rd);
        check_eq("status_clr", rd, 32'h0);
        check_eq("irq_clr", irq, 0);

        // Start while busy, then W1C racing core_done
        core_busy = 1;
        do_write(AW'(0), 32'h3, 4'hF, 0, 0, 0, 0);
        tick(2);
        check_eq("busy_no_start", start_cnt, s0 + 1);
        do_read(AW'(4), rd);
        check_eq("status_err", rd, 32'h5);
        core_busy = 0;
        do_write(AW'(4), 32'h6, 4'hF, 1, 0, 0, 1);
        do_read(AW'(4), rd);
        check_eq("set_wins", rd, 32'h2);
        check_outputs("race");

        // Out of range, stalled B
        axi_write(AW'(32), 32'hDEADBEEF, 4'hF, 0, 0, 10, 0, resp);
        check_eq("oor_bresp", resp, 2'b10);
        axi_read(AW'(32), rd, resp);
        check_eq("oor_rresp", resp, 2'b10);
        check_eq("oor_rdata", rd, 0);
        check_outputs("oor");

        // Randomized traffic
        for (int k = 0; k < 200; k++) begin
            int op = int'($urandom_range(0, 9));
            logic [AW-1:0] a = {AW'($urandom_range(0, 15)) << 2} | AW'($urandom_range(0, 3));
            if (op <= 3) begin
                do_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            end else if (op <= 6) begin
                do_read(a, rd);
            end else if (op == 7) begin
                pulse_core_done();
            end else if (op == 8) begin
                core_busy = ~core_busy;
                tick(1);
            end else begin
                tick(int'($urandom_range(1, 3)));
            end
            tick(1);
            check_outputs("rand");
        end

        // Reset with an address latched: no response may follow
        core_busy = 0;
        awaddr = AW'(8); awvalid = 1;
        tick(1);
        awvalid = 0;
        reset = 1;
        tick(2);
        reset = 0;
        model_reset();
        tick(1);
        wdata = 32'h55; wstrb = 4'hF; wvalid = 1;
        tick(1);
        wvalid = 0;
        tick(4);
        check_eq("rst_drop_bvalid", bvalid, 0);
        check_eq("rst_drop_user", cfg_user, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
